// File: rtl/tsp_pkg.sv
// +--------------------------------------------------------------------+
// | tsp_pkg: state encoding, width helpers and {Y,X} field selects     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

`ifndef TSP_PKG_SV
`define TSP_PKG_SV
// City RAM words are packed {Y,X}, each W bits wide.
`define TSP_CITY_X(v, W) v[(W)-1:0]
`define TSP_CITY_Y(v, W) v[2*(W)-1:(W)]
`endif

package tsp_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_TOUR_RD = 3'd1,
    ST_CITY_RD = 3'd2,
    ST_SQUARE  = 3'd3,
    ST_SQRT    = 3'd4,
    ST_ACCUM   = 3'd5,
    ST_DONE    = 3'd6
  } tde_state_t;

  // Exact width of dx^2 + dy^2 for COORD_W-bit coordinates.
  function automatic int sq_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

  function automatic int root_w(input int sq_width);
    return (sq_width + 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_seq.sv
// +--------------------------------------------------------------------+
// | isqrt_seq: bit-serial restoring integer square root, one bit/cycle |
// | Optional TOUR_NINT_ROUND_EN adds a round-to-nearest step. Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module isqrt_seq #(
  parameter int SQ_W   = 67,
  parameter int ROOT_W = (SQ_W + 1) / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SQ_W-1:0]   radicand,
  output logic              done,
  output logic [ROOT_W-1:0] root
);

  localparam int RAD_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 2;
`ifdef TOUR_NINT_ROUND_EN
  localparam int LAST  = ROOT_W + 1;
`else
  localparam int LAST  = ROOT_W;
`endif
  localparam int CNT_W = $clog2(LAST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef TOUR_NINT_ROUND_EN
  localparam logic [CNT_W-1:0]  CNT_BITS = CNT_W'(ROOT_W);
  localparam logic [ROOT_W-1:0] ROOT_ONE = ROOT_W'(1);
`endif

  logic [RAD_W-1:0]  rad_r;
  logic [REM_W-1:0]  rem_r;
  logic [ROOT_W-1:0] root_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              run_r;

  logic [REM_W+1:0]  w_rem_sh;
  logic [REM_W+1:0]  w_trial;
  logic [REM_W-1:0]  w_diff;
  logic              w_fits;

  always_comb begin
    w_rem_sh = {rem_r, rad_r[RAD_W-1 -: 2]};
    w_trial  = {2'b00, root_r, 2'b01};
    w_fits   = (w_rem_sh >= w_trial);
    w_diff   = REM_W'(w_rem_sh - w_trial);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad_r  <= '0;
      rem_r  <= '0;
      root_r <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
    end else if (start) begin
      rad_r  <= RAD_W'(radicand);
      rem_r  <= '0;
      root_r <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == CNT_LAST) begin
        run_r <= 1'b0;
`ifdef TOUR_NINT_ROUND_EN
      end else if (cnt_r == CNT_BITS) begin
        // s - r^2 is the final remainder; round up when it exceeds r.
        if (rem_r > {2'b00, root_r}) root_r <= root_r + ROOT_ONE;
        cnt_r <= cnt_r + CNT_ONE;
`endif
      end else begin
        rad_r  <= {rad_r[RAD_W-3:0], 2'b00};
        rem_r  <= w_fits ? w_diff : w_rem_sh[REM_W-1:0];
        root_r <= {root_r[ROOT_W-2:0], w_fits};
        cnt_r  <= cnt_r + CNT_ONE;
      end
    end
  end

  assign done = run_r && (cnt_r == CNT_LAST);
  assign root = root_r;

endmodule

`default_nettype wire

// File: rtl/tour_dist_eval.sv
// +--------------------------------------------------------------------+
// | tour_dist_eval: closed-tour Euclidean length over tour/city RAMs   |
// | Rounding mode via TOUR_NINT_ROUND_EN (in isqrt_seq). Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module tour_dist_eval
  import tsp_pkg::*;
#(
  parameter int COORD_W       = 32,
  parameter int MAX_NODE_BITS = 9,
  parameter int ACC_W         = 32,
  parameter int RAM_LAT       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MAX_NODE_BITS-1:0] nnodes,
  output logic                     busy,
  output logic                     done,
  output logic                     dist_valid,
  output logic [ACC_W-1:0]         total_dist,
  output logic                     overflow,
  output logic [MAX_NODE_BITS-1:0] tour_addr,
  input  logic [MAX_NODE_BITS-1:0] tour_data,
  output logic [MAX_NODE_BITS-1:0] city_addr,
  input  logic [2*COORD_W-1:0]     city_data
);

  localparam int SQ_W   = sq_w(COORD_W);
  localparam int ROOT_W = root_w(SQ_W);
  localparam int DW     = COORD_W + 1;
  localparam int SUM_W  = ((ACC_W > ROOT_W) ? ACC_W : ROOT_W) + 1;
  localparam int LAT_W  = $clog2(RAM_LAT + 1);
  localparam logic [LAT_W-1:0]         LAT_LAST  = LAT_W'(RAM_LAT);
  localparam logic [LAT_W-1:0]         LAT_ONE   = LAT_W'(1);
  localparam logic [MAX_NODE_BITS-1:0] NODE_ONE  = MAX_NODE_BITS'(1);
  localparam logic [MAX_NODE_BITS-1:0] NODE_TWO  = MAX_NODE_BITS'(2);

  tde_state_t state_r, state_nxt;

  logic [MAX_NODE_BITS-1:0] n_r, idx_r, cidx_r;
  logic [LAT_W-1:0]         lat_r;
  logic [2*COORD_W-1:0]     cur_r, prev_r, first_r;
  logic [ACC_W-1:0]         acc_r, total_r;
  logic                     ovf_r, overflow_r, closing_r, dist_valid_r;

  logic                     sqrt_start, sqrt_done;
  logic [ROOT_W-1:0]        sqrt_root;

  logic [COORD_W-1:0]       cur_x, cur_y, prev_x, prev_y;
  logic signed [DW-1:0]     dx, dy;
  logic signed [2*DW-1:0]   dx2, dy2;
  logic [SQ_W-1:0]          sq;
  logic [SUM_W-1:0]         w_sum;
  logic                     w_sat, w_ovf_nxt, w_last_edge, w_lat_end;
  logic [ACC_W-1:0]         w_acc_nxt;

  // Coordinates are sign-extended one bit so dx/dy never wrap.
  always_comb begin
    cur_x  = `TSP_CITY_X(cur_r, COORD_W);
    cur_y  = `TSP_CITY_Y(cur_r, COORD_W);
    prev_x = `TSP_CITY_X(prev_r, COORD_W);
    prev_y = `TSP_CITY_Y(prev_r, COORD_W);
    dx     = {cur_x[COORD_W-1], cur_x} - {prev_x[COORD_W-1], prev_x};
    dy     = {cur_y[COORD_W-1], cur_y} - {prev_y[COORD_W-1], prev_y};
    dx2    = dx * dx;
    dy2    = dy * dy;
    sq     = {1'b0, dx2} + {1'b0, dy2};
  end

  always_comb begin
    w_sum       = SUM_W'(acc_r) + SUM_W'(sqrt_root);
    w_sat       = |w_sum[SUM_W-1:ACC_W];
    w_acc_nxt   = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    w_ovf_nxt   = ovf_r | w_sat;
    w_last_edge = (idx_r == n_r - NODE_ONE);
    w_lat_end   = (lat_r == LAT_LAST);
  end

  // The square is registered inside isqrt_seq when it accepts the start.
  isqrt_seq #(
    .SQ_W   (SQ_W),
    .ROOT_W (ROOT_W)
  ) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sqrt_start),
    .radicand (sq),
    .done     (sqrt_done),
    .root     (sqrt_root)
  );

  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_r;
    sqrt_start = 1'b0;
    case (state_r)
      ST_IDLE:    if (start) state_nxt = (nnodes >= NODE_TWO) ? ST_TOUR_RD : ST_DONE;
      ST_TOUR_RD: if (w_lat_end) state_nxt = ST_CITY_RD;
      ST_CITY_RD: if (w_lat_end) state_nxt = (idx_r == '0) ? ST_TOUR_RD : ST_SQUARE;
      ST_SQUARE: begin
        sqrt_start = 1'b1;
        state_nxt  = ST_SQRT;
      end
      ST_SQRT:    if (sqrt_done) state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        if (closing_r)        state_nxt = ST_DONE;
        else if (w_last_edge) state_nxt = ST_SQUARE;
        else                  state_nxt = ST_TOUR_RD;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_r          <= '0;
      idx_r        <= '0;
      cidx_r       <= '0;
      lat_r        <= '0;
      cur_r        <= '0;
      prev_r       <= '0;
      first_r      <= '0;
      acc_r        <= '0;
      ovf_r        <= 1'b0;
      closing_r    <= 1'b0;
      total_r      <= '0;
      overflow_r   <= 1'b0;
      dist_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_r          <= nnodes;
            idx_r        <= '0;
            lat_r        <= '0;
            acc_r        <= '0;
            ovf_r        <= 1'b0;
            closing_r    <= 1'b0;
            dist_valid_r <= 1'b0;
            if (nnodes < NODE_TWO) begin
              total_r      <= '0;
              overflow_r   <= 1'b0;
              dist_valid_r <= 1'b1;
            end
          end
        end
        ST_TOUR_RD: begin
          if (w_lat_end) begin
            lat_r  <= '0;
            cidx_r <= tour_data;
          end else begin
            lat_r <= lat_r + LAT_ONE;
          end
        end
        ST_CITY_RD: begin
          if (w_lat_end) begin
            lat_r <= '0;
            cur_r <= city_data;
            if (idx_r == '0) begin
              first_r <= city_data;
              prev_r  <= city_data;
              idx_r   <= NODE_ONE;
            end
          end else begin
            lat_r <= lat_r + LAT_ONE;
          end
        end
        ST_ACCUM: begin
          acc_r <= w_acc_nxt;
          ovf_r <= w_ovf_nxt;
          if (closing_r) begin
            total_r      <= w_acc_nxt;
            overflow_r   <= w_ovf_nxt;
            dist_valid_r <= 1'b1;
          end else if (w_last_edge) begin
            prev_r    <= cur_r;
            cur_r     <= first_r;
            closing_r <= 1'b1;
          end else begin
            prev_r <= cur_r;
            idx_r  <= idx_r + NODE_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_r != ST_IDLE) && (state_r != ST_DONE);
  assign done       = (state_r == ST_DONE);
  assign dist_valid = dist_valid_r;
  assign total_dist = total_r;
  assign overflow   = overflow_r;
  assign tour_addr  = idx_r;
  assign city_addr  = cidx_r;

endmodule

`default_nettype wire

// File: tb/tb_tour_dist_eval.sv
// +--------------------------------------------------------------------+
// | tb_tour_dist_eval: directed vector bench for tour_dist_eval        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_tour_dist_eval;

`ifdef TOUR_NINT_ROUND_EN
  localparam bit ROUND_MODE = 1'b1;
`else
  localparam bit ROUND_MODE = 1'b0;
`endif
  localparam int ROOT_W   = 34;  // ceil((2*32+3)/2)
  localparam int SQRT_CYC = ROOT_W + 1 + (ROUND_MODE ? 1 : 0);

  function automatic int edge_cyc(input int lat);
    return 2 * (lat + 1) + 1 + SQRT_CYC + 1;
  endfunction

  function automatic logic [63:0] xy(input int x, input int y);
    return {y, x};
  endfunction

  typedef struct packed {
    logic [8:0]       n;
    logic [3:0][63:0] city;
    logic [3:0][8:0]  tour;
    logic [31:0]      exp_total;
    logic             exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic [8:0] n,
                              input logic [63:0] c0, input logic [63:0] c1,
                              input logic [63:0] c2, input logic [63:0] c3,
                              input logic [8:0] t0, input logic [8:0] t1,
                              input logic [8:0] t2, input logic [8:0] t3,
                              input logic [31:0] e, input logic o);
    vec_t v;
    v.n = n;
    v.city[0] = c0; v.city[1] = c1; v.city[2] = c2; v.city[3] = c3;
    v.tour[0] = t0; v.tour[1] = t1; v.tour[2] = t2; v.tour[3] = t3;
    v.exp_total = e;
    v.exp_ovf = o;
    return v;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: default widths, RAM_LAT=1
  logic        a_start = 1'b0;
  logic [8:0]  a_nnodes = '0;
  logic        a_busy, a_done, a_dv, a_ovf;
  logic [31:0] a_total;
  logic [8:0]  a_taddr, a_caddr;
  logic [8:0]  a_tdata;
  logic [63:0] a_cdata;
  logic [8:0]  a_tour [0:511];
  logic [63:0] a_city [0:511];

  always @(posedge clk) begin
    a_tdata <= a_tour[a_taddr];
    a_cdata <= a_city[a_caddr];
  end

  tour_dist_eval #(
    .COORD_W(32), .MAX_NODE_BITS(9), .ACC_W(32), .RAM_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .nnodes(a_nnodes),
    .busy(a_busy), .done(a_done), .dist_valid(a_dv), .total_dist(a_total),
    .overflow(a_ovf), .tour_addr(a_taddr), .tour_data(a_tdata),
    .city_addr(a_caddr), .city_data(a_cdata)
  );

  // DUT B: 8-bit accumulator, RAM_LAT=2
  logic        b_start = 1'b0;
  logic [8:0]  b_nnodes = '0;
  logic        b_busy, b_done, b_dv, b_ovf;
  logic [7:0]  b_total;
  logic [8:0]  b_taddr, b_caddr;
  logic [8:0]  b_t1, b_tdata;
  logic [63:0] b_c1, b_cdata;
  logic [8:0]  b_tour [0:511];
  logic [63:0] b_city [0:511];

  always @(posedge clk) begin
    b_t1    <= b_tour[b_taddr];
    b_tdata <= b_t1;
    b_c1    <= b_city[b_caddr];
    b_cdata <= b_c1;
  end

  tour_dist_eval #(
    .COORD_W(32), .MAX_NODE_BITS(9), .ACC_W(8), .RAM_LAT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .nnodes(b_nnodes),
    .busy(b_busy), .done(b_done), .dist_valid(b_dv), .total_dist(b_total),
    .overflow(b_ovf), .tour_addr(b_taddr), .tour_data(b_tdata),
    .city_addr(b_caddr), .city_data(b_cdata)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load_a(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      a_city[k] = v.city[k];
      a_tour[k] = v.tour[k];
    end
  endtask

  task automatic run_a(input string tag, input logic [8:0] n, input logic [31:0] exp_t,
                       input logic exp_o, input bit poke);
    int cyc;
    int exp_cyc;
    bit seen;
    exp_cyc = (n < 9'd2) ? 1 : int'(n) * edge_cyc(1) + 1;
    @(negedge clk);
    a_nnodes = n;
    a_start  = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    if (n >= 9'd2) chk({tag, "_busy"}, a_busy, 1);
    while (cyc < 3000) begin
      if (a_done) begin
        seen = 1'b1;
        break;
      end
      a_start  = poke && (cyc == 30);
      a_nnodes = poke ? 9'd0 : n;
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_total"}, a_total, exp_t);
    chk({tag, "_ovf"}, a_ovf, exp_o);
    chk({tag, "_dv"}, a_dv, 1);
    chk({tag, "_busy_in_done"}, a_busy, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, a_done, 0);
    chk({tag, "_dv_hold"}, a_dv, 1);
    chk({tag, "_total_hold"}, a_total, exp_t);
  endtask

  vec_t vecs [7];

  initial begin
    int cyc;
    bit seen;

    vecs[0] = mk(9'd4, xy(0, 0), xy(3, 0), xy(3, 4), xy(0, 4),
                 9'd0, 9'd1, 9'd2, 9'd3, 32'd14, 1'b0);
    vecs[1] = mk(9'd4, xy(0, 0), xy(10, 0), xy(0, 10), xy(10, 10),
                 9'd0, 9'd1, 9'd3, 9'd2, 32'd40, 1'b0);
    vecs[2] = mk(9'd4, xy(0, 0), xy(10, 0), xy(0, 10), xy(10, 10),
                 9'd0, 9'd3, 9'd1, 9'd2, 32'd48, 1'b0);
    vecs[3] = mk(9'd2, xy(0, 0), xy(2, 3), 64'd0, 64'd0,
                 9'd0, 9'd1, 9'd0, 9'd0, ROUND_MODE ? 32'd8 : 32'd6, 1'b0);
    vecs[4] = mk(9'd2, xy(-3, -4), xy(0, 0), 64'd0, 64'd0,
                 9'd1, 9'd0, 9'd0, 9'd0, 32'd10, 1'b0);
    vecs[5] = mk(9'd2, xy(0, 0), xy(32'sh7FFF_FFFF, 0), 64'd0, 64'd0,
                 9'd0, 9'd1, 9'd0, 9'd0, 32'hFFFF_FFFE, 1'b0);
    vecs[6] = mk(9'd2, xy(32'sh8000_0000, 0), xy(32'sh7FFF_FFFF, 0), 64'd0, 64'd0,
                 9'd0, 9'd1, 9'd0, 9'd0, 32'hFFFF_FFFF, 1'b1);

    for (int k = 0; k < 512; k++) begin
      a_tour[k] = '0; a_city[k] = '0;
      b_tour[k] = '0; b_city[k] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_dv", a_dv, 0);
    chk("rst_total", a_total, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_taddr", a_taddr, 0);
    chk("rst_caddr", a_caddr, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_a(vecs[i]);
      run_a($sformatf("vec%0d", i), vecs[i].n, vecs[i].exp_total, vecs[i].exp_ovf, i == 1);
    end

    run_a("n1", 9'd1, 32'd0, 1'b0, 1'b0);
    run_a("n0", 9'd0, 32'd0, 1'b0, 1'b0);

    // Abort during the first square root, then rerun cleanly.
    load_a(vecs[2]);
    run_a("pre_abort", 9'd4, 32'd48, 1'b0, 1'b0);
    load_a(vecs[0]);
    @(negedge clk);
    a_nnodes = 9'd4;
    a_start  = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", a_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_dv", a_dv, 0);
    chk("abort_total", a_total, 0);
    chk("abort_ovf", a_ovf, 0);
    chk("abort_taddr", a_taddr, 0);
    chk("abort_caddr", a_caddr, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (a_done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    run_a("after_abort", 9'd4, 32'd14, 1'b0, 1'b0);

    // Saturation on the 8-bit accumulator instance.
    b_city[0] = xy(0, 0);
    b_city[1] = xy(100, 0);
    b_city[2] = xy(100, 100);
    b_tour[0] = 9'd0;
    b_tour[1] = 9'd1;
    b_tour[2] = 9'd2;
    @(negedge clk);
    b_nnodes = 9'd3;
    b_start  = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 3000) begin
      if (b_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("sat_done_seen", seen, 1);
    chk("sat_latency", cyc, 3 * edge_cyc(2) + 1);
    chk("sat_total", b_total, 8'hFF);
    chk("sat_ovf", b_ovf, 1);
    chk("sat_dv", b_dv, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
